// File: rtl/zc_square_gen.sv
// Sine-to-square converter: windowed DC-offset estimate, hysteretic crossing
// detector with holdoff, three square-wave modes, period measurement and lock flag.
module zc_square_gen #(
    parameter int DATA_W   = 29,
    parameter int WIN_LOG2 = 10,
    parameter int CNT_W    = 32,
    parameter int HOLDOFF  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    input  logic        [DATA_W-2:0] hyst,
    input  logic        [1:0]        mode,
    output logic                     square_out,
    output logic        [CNT_W-1:0]  period,
    output logic                     period_valid,
    output logic signed [DATA_W-1:0] mean_out,
    output logic                     mean_valid,
    output logic                     locked
);

    localparam int ACC_W = DATA_W + WIN_LOG2;
    localparam int CMP_W = DATA_W + 2;
    localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ST_ARM: a fresh mean exists; the next valid sample picks the starting side.
    typedef enum logic [1:0] {ST_ACQ, ST_ARM, ST_LOW, ST_HIGH} state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0]  acc, acc_sum;
    logic        [WIN_LOG2-1:0] win_cnt;
    logic                     win_last;
    logic        [CNT_W-1:0]  cnt, cnt_inc;
    logic        [HO_W-1:0]   holdoff_cnt;
    logic                     have_ref;
    logic signed [CMP_W-1:0]  din_x, mean_x, hyst_x, thr_hi, thr_lo;
    logic                     armed, rise_x, fall_x, square_nxt;

    assign acc_sum  = acc + ACC_W'(din);
    assign win_last = &win_cnt;
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // Thresholds are two bits wider than the sample so mean +/- hyst never wraps.
    assign din_x  = CMP_W'(din);
    assign mean_x = CMP_W'(mean_out);
    assign hyst_x = signed'({3'b000, hyst});
    assign thr_hi = mean_x + hyst_x;
    assign thr_lo = mean_x - hyst_x;
    assign armed  = en && din_valid && (holdoff_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_ACQ;
        else      state <= state_nxt;
    end

    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_ACQ;
        end else if (din_valid) begin
            case (state)
                ST_ACQ:  if (win_last) state_nxt = ST_ARM;
                ST_ARM:  state_nxt = (din_x > mean_x) ? ST_HIGH : ST_LOW;
                ST_LOW:  if (armed && (din_x > thr_hi)) state_nxt = ST_HIGH;
                ST_HIGH: if (armed && (din_x < thr_lo)) state_nxt = ST_LOW;
                default: state_nxt = ST_ACQ;
            endcase
        end
    end

    always_comb begin
        rise_x     = armed && (state == ST_LOW)  && (din_x > thr_hi);
        fall_x     = armed && (state == ST_HIGH) && (din_x < thr_lo);
        square_nxt = square_out;
        if (en && din_valid && (state == ST_ARM)) begin
            // Toggle modes start from the current level; comparator mode follows the side.
            if ((mode == 2'b00) || (mode == 2'b11)) square_nxt = (din_x > mean_x);
        end else if (rise_x) begin
            square_nxt = ((mode == 2'b01) || (mode == 2'b10)) ? ~square_out : 1'b1;
        end else if (fall_x) begin
            case (mode)
                2'b01:   square_nxt = square_out;
                2'b10:   square_nxt = ~square_out;
                default: square_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc          <= '0;
            win_cnt      <= '0;
            cnt          <= '0;
            holdoff_cnt  <= '0;
            have_ref     <= 1'b0;
            square_out   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            mean_out     <= '0;
            mean_valid   <= 1'b0;
            locked       <= 1'b0;
        end else begin
            mean_valid   <= 1'b0;
            period_valid <= 1'b0;
            if (!en) begin
                acc         <= '0;
                win_cnt     <= '0;
                cnt         <= '0;
                holdoff_cnt <= '0;
                have_ref    <= 1'b0;
                square_out  <= 1'b0;
                locked      <= 1'b0;
            end else if (din_valid) begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
                if (win_last) begin
                    mean_out   <= DATA_W'(acc_sum >>> WIN_LOG2);
                    mean_valid <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= acc_sum;
                end

                if (holdoff_cnt != '0)    holdoff_cnt <= holdoff_cnt - HO_W'(1);
                else if (rise_x || fall_x) holdoff_cnt <= HO_W'(HOLDOFF);

                square_out <= square_nxt;

                if (rise_x) begin
                    cnt      <= '0;
                    have_ref <= 1'b1;
                    // The first rise after acquisition only establishes the reference.
                    if (have_ref) begin
                        period       <= cnt_inc;
                        period_valid <= 1'b1;
                        locked       <= (cnt != CNT_MAX);
                    end
                end else begin
                    cnt <= cnt_inc;
                    if (cnt_inc == CNT_MAX) locked <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_zc_square_gen.sv
// Directed bench for zc_square_gen: offset removal, hysteresis, holdoff, modes,
// counter saturation, enable drop and asynchronous reset.
module tb_zc_square_gen;

    localparam int DW = 16;
    localparam int WL = 4;
    localparam int CW = 8;
    localparam int HO = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic        [DW-2:0] hyst;
    logic        [1:0]    mode;
    logic                 square_out;
    logic        [CW-1:0] period;
    logic                 period_valid;
    logic signed [DW-1:0] mean_out;
    logic                 mean_valid;
    logic                 locked;

    int n_total = 0;
    int n_bad   = 0;
    int k;
    int ones;

    zc_square_gen #(.DATA_W(DW), .WIN_LOG2(WL), .CNT_W(CW), .HOLDOFF(HO)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .hyst(hyst), .mode(mode), .square_out(square_out), .period(period),
        .period_valid(period_valid), .mean_out(mean_out), .mean_valid(mean_valid),
        .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Test tone: 8 samples of +1500 then 8 of -500, mean 500.
    function automatic logic signed [DW-1:0] pat(input int i);
        return ((i % 16) < 8) ? 16'sd1500 : -16'sd500;
    endfunction

    task automatic smp(input logic signed [DW-1:0] d);
        @(negedge clk);
        din       = d;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int k_end);
        while (k <= k_end) begin
            smp(pat(k));
            k++;
        end
    endtask

    task automatic drop_en();
        @(negedge clk);
        en        = 1'b0;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; din = '0; din_valid = 1'b0; hyst = '0; mode = 2'b00; k = 0;
        #12;
        check("rst_square", square_out, 0);
        check("rst_period", period, 0);
        check("rst_pv", period_valid, 0);
        check("rst_mean", mean_out, 0);
        check("rst_mv", mean_valid, 0);
        check("rst_locked", locked, 0);
        @(negedge clk);
        rst = 1'b1;

        // Offset removal and comparator mode
        run_to(14);  check("mv_early", mean_valid, 0);
        run_to(15);  check("mv_first", mean_valid, 1);
                     check("mean_first", mean_out, 500);
        run_to(16);  check("arm_high", square_out, 1);
                     check("arm_no_pv", period_valid, 0);
        run_to(24);  check("fall_1", square_out, 0);
        run_to(32);  check("rise_1", square_out, 1);
                     check("first_rise_no_pv", period_valid, 0);
                     check("unlocked_1", locked, 0);
        run_to(48);  check("pv_2", period_valid, 1);
                     check("period_2", period, 16);
                     check("locked_2", locked, 1);
        run_to(49);  check("pv_strobe", period_valid, 0);
        run_to(64);  check("period_3", period, 16);
                     check("pv_3", period_valid, 1);
        ones = 0;
        for (int j = 0; j < 16; j++) begin
            run_to(k);
            ones += int'(square_out);
        end
        check("duty_mode00", ones, 8);

        // Toggle on rising crossing
        mode = 2'b01;
        idle();      check("mode_no_jump", square_out, 1);
                     check("idle_pv_low", period_valid, 0);
                     check("idle_mv_low", mean_valid, 0);
        run_to(88);  check("m01_fall_hold", square_out, 1);
        run_to(96);  check("m01_rise_tog", square_out, 0);
        run_to(104); check("m01_fall_hold2", square_out, 0);
        run_to(112); check("m01_rise_tog2", square_out, 1);

        // Toggle on every crossing
        mode = 2'b10;
        run_to(120); check("m10_a", square_out, 0);
        run_to(128); check("m10_b", square_out, 1);
        run_to(136); check("m10_c", square_out, 0);
        mode = 2'b00;
        run_to(144); check("m00_back_hi", square_out, 1);
        run_to(152); check("m00_back_lo", square_out, 0);
                     check("locked_modes", locked, 1);

        // Hysteresis band around mean 500
        run_to(159); check("mean_hyst", mean_out, 500);
        hyst = 15'd100;
        for (int j = 0; j < 8; j++) begin
            smp(((j % 2) == 0) ? 16'sd450 : 16'sd550);
            check("hyst_band", square_out, 0);
        end
        smp(16'sd600); check("at_hi_edge", square_out, 0);
        smp(16'sd601); check("hyst_rise", square_out, 1);
                       check("hyst_pv", period_valid, 1);
                       check("hyst_period", period, 25);
        for (int j = 0; j < 3; j++) smp(16'sd550);
        smp(16'sd400); check("at_lo_edge", square_out, 1);
        smp(16'sd399); check("hyst_fall", square_out, 0);
        smp(16'sd350); check("mv_hyst_win", mean_valid, 1);
                       check("mean_hyst_win", mean_out, 500);

        // Holdoff against chatter
        hyst = '0;
        smp(16'sd500);
        smp(16'sd500);
        smp(16'sd600); check("ho_rise", square_out, 1);
                       check("ho_period", period, 9);
        smp(16'sd490); check("ho_chat1", square_out, 1);
        smp(16'sd510); check("ho_chat2", square_out, 1);
        smp(16'sd490); check("ho_chat3", square_out, 1);
        smp(16'sd510); check("ho_after", square_out, 1);
        smp(16'sd490); check("ho_fall", square_out, 0);

        // Counter saturation and lock loss
        check("sat_pre_locked", locked, 1);
        for (int j = 0; j < 3; j++) smp(16'sd1000);
        check("sat_ho_block", square_out, 0);
        smp(16'sd1000); check("sat_rise", square_out, 1);
                        check("sat_rise_period", period, 9);
        for (int j = 1; j <= 255; j++) begin
            smp(16'sd1000);
            if (j == 254) check("sat_locked_254", locked, 1);
            if (j == 255) check("sat_unlocked_255", locked, 0);
        end
        smp(16'sd1000); check("sat_stays_unlocked", locked, 0);
        smp(-16'sd1000); check("sat_fall", square_out, 0);
        for (int j = 0; j < 3; j++) smp(-16'sd1000);
        smp(16'sd2000); check("sat_pv", period_valid, 1);
                        check("sat_period", period, 255);

        // Enable drop: reacquire, lock, then drop while locked
        drop_en();   check("en1_locked", locked, 0);
                     check("en1_square", square_out, 0);
        k = 0;
        run_to(15);  check("en1_mean", mean_out, 500);
        run_to(48);  check("en1_relock", locked, 1);
                     check("en1_period", period, 16);
                     check("en1_sq", square_out, 1);
        drop_en();   check("en2_locked", locked, 0);
                     check("en2_square", square_out, 0);
                     check("en2_mean_kept", mean_out, 500);
                     check("en2_period_kept", period, 16);
        k = 0;
        run_to(7);   check("acq_waits_mean", square_out, 0);
        run_to(15);  check("acq_mv", mean_valid, 1);
                     check("acq_sq", square_out, 0);
        run_to(16);  check("acq_exit_high", square_out, 1);

        // Asynchronous reset mid-window
        run_to(20);
        #2;
        rst = 1'b0;
        #1;
        check("arst_square", square_out, 0);
        check("arst_period", period, 0);
        check("arst_pv", period_valid, 0);
        check("arst_mean", mean_out, 0);
        check("arst_mv", mean_valid, 0);
        check("arst_locked", locked, 0);
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        run_to(14);  check("partial_discarded", mean_valid, 0);
        run_to(15);  check("arst_mv_full", mean_valid, 1);
                     check("arst_mean_full", mean_out, 500);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
